// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Data-bus bundle between the MEM stage (master) and the data memory / cache
// (slave). One transaction: the master holds data_req with a stable address,
// size, write data and strobes until data_addr_ok. The slave later returns
// data_data_ok, with data_rdata for reads.
//
//   data_req      master->slave  request valid
//   data_wr       master->slave  1 = write, 0 = read
//   data_size     master->slave  00 byte, 01 half, 10 word
//   data_addr     master->slave  byte address (unmodified ALU result)
//   data_wdata    master->slave  lane-replicated store data
//   data_wstrb    master->slave  byte-lane write enables (0000 for reads)
//   data_addr_ok  slave->master  request accepted this cycle
//   data_data_ok  slave->master  read data valid / write complete
//   data_rdata    slave->master  raw 32-bit read word
// -----------------------------------------------------------------------------
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage sitting right after EX. For a load or store it runs one
// data-bus transaction, aligning store data/strobes and extending load data.
// It flags misaligned accesses as address errors without touching the bus,
// and it stalls upstream while a transaction is in flight. The pipeline
// control fields pass through to the MEM/WB register.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   MemRead_i / MemWrite_i   load / store present in this stage
//   MemReadType_i[2:0]       [1:0] size (11 treated as word), [2] zero-extend
//   ALUResult_i              effective address or plain ALU result
//   MemData_i                store data
//   RegWrite_i, MemtoReg_i, WriteRegister_i, PCin   pass-through fields
//   pipe_hold_i              downstream stall; stage inputs stay frozen
//   bus                      data-bus master (see mem_access_stage_if)
//   RegWrite_o ... PCout     pass-through (RegWrite_o killed on address error)
//   MemReadData              aligned, extended load result
//   stall                    stage busy, upstream must hold
//   exception                00 none, 01 AdEL, 10 AdES
//   BadVAddr                 faulting address, 0 when no exception
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemRead_i,
    input  logic                MemWrite_i,
    input  logic [2:0]          MemReadType_i,
    input  logic [ADDR_W-1:0]   ALUResult_i,
    input  logic [DATA_W-1:0]   MemData_i,
    input  logic                RegWrite_i,
    input  logic                MemtoReg_i,
    input  logic [6:0]          WriteRegister_i,
    input  logic [31:0]         PCin,
    input  logic                pipe_hold_i,
    mem_access_stage_if.master  bus,
    output logic                RegWrite_o,
    output logic                MemtoReg_o,
    output logic [6:0]          WriteRegister_o,
    output logic [ADDR_W-1:0]   ALUResult_o,
    output logic [31:0]         PCout,
    output logic [DATA_W-1:0]   MemReadData,
    output logic                stall,
    output logic [1:0]          exception,
    output logic [ADDR_W-1:0]   BadVAddr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    // Reserved size code 11 behaves as a word access.
    function automatic logic [1:0] eff_size(input logic [1:0] t);
        return (t == 2'b11) ? 2'b10 : t;
    endfunction

    function automatic logic [DATA_W-1:0] store_align(input logic [DATA_W-1:0] d,
                                                      input logic [1:0] sz);
        logic [DATA_W-1:0] res;
        case (sz)
            2'b00:   res = {4{d[7:0]}};
            2'b01:   res = {2{d[15:0]}};
            default: res = d;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] res;
        case (sz)
            2'b00:   res = 4'b0001 << off;
            2'b01:   res = off[1] ? 4'b1100 : 4'b0011;
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0] sz,
                                                      input logic [1:0] off,
                                                      input logic zext);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [DATA_W-1:0]  res;
        b = raw[{off, 3'b000} +: 8];
        h = raw[{off[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   res = zext ? {24'h0, b} : 32'(b);
            2'b01:   res = zext ? {16'h0, h} : 32'(h);
            default: res = raw;
        endcase
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        size;
    logic              mem_op;
    logic              misaligned;
    logic              access;
    logic              exc_load;
    logic              exc_store;
    logic [DATA_W-1:0] load_val;

    assign size       = eff_size(MemReadType_i[1:0]);
    assign mem_op     = MemRead_i | MemWrite_i;
    assign misaligned = ((size == 2'b01) & ALUResult_i[0]) |
                        ((size == 2'b10) & (ALUResult_i[1:0] != 2'b00));
    // No new request is launched while reset is held.
    assign access     = mem_op & ~misaligned & ~rst;
    assign load_val   = load_extend(bus.data_rdata, size, ALUResult_i[1:0], MemReadType_i[2]);

    assign exc_load   = MemRead_i  & misaligned & ~rst;
    assign exc_store  = MemWrite_i & misaligned & ~rst;
    assign exception  = {exc_store, exc_load};
    assign BadVAddr   = (exc_load | exc_store) ? ALUResult_i : '0;

    // Address/data/strobes come straight from the frozen stage inputs, so they
    // remain stable for as long as the request is outstanding.
    assign bus.data_addr  = ALUResult_i;
    assign bus.data_size  = size;
    assign bus.data_wdata = store_align(MemData_i, size);
    assign bus.data_wstrb = MemWrite_i ? store_strb(size, ALUResult_i[1:0]) : 4'b0000;
    assign bus.data_wr    = bus.data_req & MemWrite_i;

    assign RegWrite_o      = RegWrite_i & ~(mem_op & misaligned);
    assign MemtoReg_o      = MemtoReg_i;
    assign WriteRegister_o = WriteRegister_i;
    assign ALUResult_o     = ALUResult_i;
    assign PCout           = PCin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        bus.data_req = 1'b0;
        stall        = 1'b0;
        MemReadData  = rdata_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    bus.data_req = 1'b1;
                    stall        = 1'b1;
                    state_d      = bus.data_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                bus.data_req = 1'b1;
                stall        = 1'b1;
                if (bus.data_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (bus.data_data_ok) begin
                    // Load data is forwarded in the completion cycle and kept
                    // in rdata_q in case downstream is holding.
                    if (MemRead_i) begin
                        rdata_d     = load_val;
                        MemReadData = load_val;
                    end
                    state_d = pipe_hold_i ? DONE : IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            DONE: begin
                if (!pipe_hold_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_i, MemWrite_i;
    logic [2:0]  MemReadType_i;
    logic [31:0] ALUResult_i, MemData_i;
    logic        RegWrite_i, MemtoReg_i;
    logic [6:0]  WriteRegister_i;
    logic [31:0] PCin;
    logic        pipe_hold_i;
    logic        RegWrite_o, MemtoReg_o;
    logic [6:0]  WriteRegister_o;
    logic [31:0] ALUResult_o, PCout, MemReadData;
    logic        stall;
    logic [1:0]  exception;
    logic [31:0] BadVAddr;

    always #5 clk = ~clk;

    mem_access_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemReadType_i(MemReadType_i),
        .ALUResult_i(ALUResult_i), .MemData_i(MemData_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .WriteRegister_i(WriteRegister_i),
        .PCin(PCin), .pipe_hold_i(pipe_hold_i), .bus(bus.master),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .WriteRegister_o(WriteRegister_o),
        .ALUResult_o(ALUResult_o), .PCout(PCout), .MemReadData(MemReadData),
        .stall(stall), .exception(exception), .BadVAddr(BadVAddr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_exp_t;

    typedef struct {
        logic        is_load;
        logic [31:0] rd;
        logic [1:0]  exc;
        logic [31:0] bad;
        logic        regw;
        logic        m2r;
        logic [6:0]  wreg;
        logic [31:0] alu;
        logic [31:0] pc;
        int          stalls;
    } ret_exp_t;

    bus_exp_t bus_q[$];
    ret_exp_t ret_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit abort    = 0;
    bit inst_active = 0;
    int stall_cnt = 0;

    // slave behaviour for the current transaction
    int          cur_a = 0, cur_d = 1;
    logic [31:0] cur_rdata = '0;

    // values captured by the monitors for constant spot checks
    logic [31:0] last_rd, last_bad, last_wdata;
    logic [1:0]  last_exc, last_size;
    logic        last_regw, last_wr;
    logic [3:0]  last_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] t);
        return (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] typ);
        int nb;
        longint span, v;
        nb   = size_bytes(typ[1:0]);
        span = longint'(1) << (8 * nb);
        v    = (longint'(word) >> (8 * int'(addr[1:0]))) % span;
        if (!typ[2] && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] d, input int nb);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] addr, input int nb);
        logic [3:0] s;
        int lo;
        s  = '0;
        lo = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) if (i >= lo && i < lo + nb) s[i] = 1'b1;
        return s;
    endfunction

    // ---------------- bus slave ----------------
    initial begin
        int req_cnt;
        int d_left;
        bit pend;
        req_cnt = 0; d_left = 0; pend = 0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
        forever begin
            @(posedge clk); #2;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            bus.data_rdata   = $urandom;
            if (rst) begin
                pend = 0; req_cnt = 0;
            end else if (pend) begin
                d_left--;
                if (d_left == 0) begin
                    bus.data_data_ok = 1'b1;
                    bus.data_rdata   = cur_rdata;
                    pend = 0;
                end
            end else if (bus.data_req) begin
                if (req_cnt == cur_a) begin
                    bus.data_addr_ok = 1'b1;
                    pend    = 1;
                    d_left  = cur_d;
                    req_cnt = 0;
                end else begin
                    req_cnt++;
                end
            end
        end
    end

    // ---------------- bus request monitor ----------------
    always @(negedge clk) begin
        if (!rst && bus.data_req) begin
            if (bus_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_req: got addr 0x%08h expected no request", bus.data_addr);
            end else begin
                chk("bus_addr", bus.data_addr, bus_q[0].addr);
                chk("bus_wr", 32'(bus.data_wr), 32'(bus_q[0].wr));
                chk("bus_size", 32'(bus.data_size), 32'(bus_q[0].size));
                chk("bus_wstrb", 32'(bus.data_wstrb), 32'(bus_q[0].wstrb));
                if (bus_q[0].wr) chk("bus_wdata", bus.data_wdata, bus_q[0].wdata);
                if (bus.data_addr_ok) begin
                    last_wdata = bus.data_wdata;
                    last_wstrb = bus.data_wstrb;
                    last_size  = bus.data_size;
                    last_wr    = bus.data_wr;
                    void'(bus_q.pop_front());
                end
            end
        end
    end

    // ---------------- retire monitor ----------------
    always @(negedge clk) begin
        if (!rst && inst_active) begin
            if (stall) begin
                stall_cnt++;
            end else begin
                chk("no_req_when_free", 32'(bus.data_req), 32'd0);
                if (ret_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_retire: got output with expected queue empty");
                end else begin
                    if (ret_q[0].is_load) chk("load_data", MemReadData, ret_q[0].rd);
                    if (!pipe_hold_i) begin
                        chk("exception", 32'(exception), 32'(ret_q[0].exc));
                        chk("badvaddr", BadVAddr, ret_q[0].bad);
                        chk("regwrite", 32'(RegWrite_o), 32'(ret_q[0].regw));
                        chk("memtoreg", 32'(MemtoReg_o), 32'(ret_q[0].m2r));
                        chk("wreg", 32'(WriteRegister_o), 32'(ret_q[0].wreg));
                        chk("aluresult", ALUResult_o, ret_q[0].alu);
                        chk("pc", PCout, ret_q[0].pc);
                        chk("stall_cycles", 32'(stall_cnt), 32'(ret_q[0].stalls));
                        last_rd   = MemReadData;
                        last_exc  = exception;
                        last_bad  = BadVAddr;
                        last_regw = RegWrite_o;
                        stall_cnt = 0;
                        void'(ret_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // kind: 0 non-memory, 1 load, 2 store. Entered and left at posedge+1.
    task automatic run_inst(input int kind, input logic [31:0] addr, input logic [2:0] typ,
                            input logic [31:0] sdata, input logic [31:0] rword,
                            input int a, input int d, input int hold_n);
        ret_exp_t r;
        bus_exp_t b;
        int  nb, nonstall;
        bit  mis, go, done;
        nb  = size_bytes(typ[1:0]);
        mis = (kind != 0) && ((int'(addr[1:0]) % nb) != 0);
        go  = (kind != 0) && !mis;
        cur_a = a; cur_d = d; cur_rdata = rword;

        MemRead_i       = (kind == 1);
        MemWrite_i      = (kind == 2);
        MemReadType_i   = typ;
        ALUResult_i     = addr;
        MemData_i       = sdata;
        RegWrite_i      = 1'($urandom_range(0, 1));
        MemtoReg_i      = 1'($urandom_range(0, 1));
        WriteRegister_i = 7'($urandom);
        PCin            = $urandom;

        r.is_load = (kind == 1) && !mis;
        r.rd      = ref_load(rword, addr, typ);
        r.exc     = !mis ? 2'b00 : (kind == 1) ? 2'b01 : 2'b10;
        r.bad     = mis ? addr : 32'h0;
        r.regw    = mis ? 1'b0 : RegWrite_i;
        r.m2r     = MemtoReg_i;
        r.wreg    = WriteRegister_i;
        r.alu     = addr;
        r.pc      = PCin;
        r.stalls  = go ? a + d : 0;
        ret_q.push_back(r);
        if (go) begin
            b.addr  = addr;
            b.wr    = (kind == 2);
            b.size  = (nb == 1) ? 2'b00 : (nb == 2) ? 2'b01 : 2'b10;
            b.wdata = ref_store(sdata, nb);
            b.wstrb = (kind == 2) ? ref_strb(addr, nb) : 4'b0000;
            bus_q.push_back(b);
        end

        inst_active = 1;
        pipe_hold_i = (hold_n > 0);
        nonstall = 0;
        done = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (!stall) begin
                if (!pipe_hold_i) done = 1;
                else nonstall++;
            end
            if (!done) begin
                @(posedge clk); #1;
                pipe_hold_i = (nonstall < hold_n);
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL timeout: got no retire within 64 cycles, expected retire at addr 0x%08h", addr);
            abort = 1;
        end
        @(posedge clk); #1;
        pipe_hold_i = 1'b0;
    endtask

    task automatic idle_inputs();
        MemRead_i = 0; MemWrite_i = 0; MemReadType_i = '0; ALUResult_i = '0; MemData_i = '0;
        RegWrite_i = 0; MemtoReg_i = 0; WriteRegister_i = '0; PCin = '0; pipe_hold_i = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_wr", 32'(bus.data_wr), 32'd0);
        chk("rst_exception", 32'(exception), 32'd0);
        chk("rst_badvaddr", BadVAddr, 32'd0);
        chk("rst_memreaddata", MemReadData, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // lw 0x100, accepted at once, data two cycles later
        run_inst(1, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 0, 2, 0);
        chk("lw_const", last_rd, 32'hDEADBEEF);
        // lb / lbu from the top byte lane
        run_inst(1, 32'h103, 3'b000, 32'h0, 32'h80000000, 1, 1, 0);
        chk("lb_const", last_rd, 32'hFFFFFF80);
        run_inst(1, 32'h103, 3'b100, 32'h0, 32'h80000000, 0, 1, 0);
        chk("lbu_const", last_rd, 32'h00000080);
        // sh to upper half
        run_inst(2, 32'h102, 3'b001, 32'h1234ABCD, 32'h0, 0, 1, 0);
        chk("sh_wdata_const", last_wdata, 32'hABCDABCD);
        chk("sh_wstrb_const", 32'(last_wstrb), 32'hC);
        chk("sh_size_const", 32'(last_size), 32'h1);
        chk("sh_wr_const", 32'(last_wr), 32'h1);
        // misaligned load / store
        run_inst(1, 32'h102, 3'b010, 32'h0, 32'h0, 0, 1, 0);
        chk("adel_const", 32'(last_exc), 32'h1);
        chk("adel_bad_const", last_bad, 32'h102);
        chk("adel_regw_const", 32'(last_regw), 32'h0);
        run_inst(2, 32'h101, 3'b010, 32'h55AA55AA, 32'h0, 0, 1, 0);
        chk("ades_const", 32'(last_exc), 32'h2);
        chk("ades_bad_const", last_bad, 32'h101);
        // slow accept plus downstream hold across completion
        run_inst(1, 32'h200, 3'b010, 32'h0, 32'hCAFEF00D, 3, 2, 5);
        chk("hold_lw_const", last_rd, 32'hCAFEF00D);

        // reset while waiting for data
        inst_active = 0;
        cur_a = 0; cur_d = 8; cur_rdata = 32'h12345678;
        begin
            bus_exp_t b;
            b.addr = 32'h300; b.wr = 0; b.size = 2'b10; b.wdata = '0; b.wstrb = 4'b0000;
            bus_q.push_back(b);
        end
        MemRead_i = 1; MemReadType_i = 3'b010; ALUResult_i = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_rst_req", 32'(bus.data_req), 32'd0);
        chk("wait_rst_stall", 32'(stall), 32'd0);
        chk("wait_rst_exception", 32'(exception), 32'd0);
        chk("wait_rst_badvaddr", BadVAddr, 32'd0);
        chk("wait_rst_memreaddata", MemReadData, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 150 && !abort; i++) begin
            int          kind, nb, a, d, h;
            logic [2:0]  typ;
            logic [31:0] addr;
            kind = $urandom_range(0, 2);
            typ  = 3'($urandom);
            nb   = size_bytes(typ[1:0]);
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (nb == 2) addr[0] = 1'b0;
                if (nb == 4) addr[1:0] = 2'b00;
            end
            a = $urandom_range(0, 3);
            d = $urandom_range(1, 3);
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_inst(kind, addr, typ, $urandom, $urandom, a, d, h);
        end
        inst_active = 0;
        idle_inputs();

        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("retire_queue_drained", 32'(ret_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
